// File: rtl/aximm_pkg.sv
// -----------------------------------------------------------------------------
// aximm_pkg
// Shared definitions for the AXI4 burst writer: the FSM state encoding, the
// AXI protocol constants and a small helper for burst length selection.
// No ports (package).
// -----------------------------------------------------------------------------
package aximm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } wr_state_t;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam int unsigned BOUNDARY_4K = 4096;

    function automatic logic [31:0] min3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/wbeat_skid.sv
// -----------------------------------------------------------------------------
// wbeat_skid
// Two-entry valid/ready buffer holding write beats (data + last flag) between
// the FIFO read side and the AXI W channel. Slot 0 is always the head, so the
// presented beat only changes when it is consumed or when the buffer was empty.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready         push handshake, in_data/in_last beat contents
//   out_valid/out_ready       pop handshake, out_data/out_last head beat
//   count                     current occupancy (0..2)
// -----------------------------------------------------------------------------
module wbeat_skid #(
    parameter int WIDTH = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] data0_q, data1_q;
    logic             last0_q, last1_q;
    logic [1:0]       cnt_q;
    logic             push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = data0_q;
    assign out_last  = last0_q;
    assign count     = cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            if (push && pop) begin
                // Only reachable with one entry: the new beat becomes the head.
                data0_q <= in_data;
                last0_q <= in_last;
            end else if (pop) begin
                data0_q <= data1_q;
                last0_q <= last1_q;
                cnt_q   <= cnt_q - 2'd1;
            end else if (push) begin
                if (cnt_q == 2'd0) begin
                    data0_q <= in_data;
                    last0_q <= in_last;
                end else begin
                    data1_q <= in_data;
                    last1_q <= in_last;
                end
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/aximm_burst_writer.sv
// -----------------------------------------------------------------------------
// aximm_burst_writer
// Streams data popped from a FIFO to memory over an AXI4 write master. Each
// pass writes `size` bytes (whole beats only) starting at dst_addr, split into
// INCR bursts that never exceed MAX_BURST beats nor cross a 4 KB boundary. The
// pass is repeated `times` times. One burst is outstanding at a time.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   ap_start/ap_ready         start request / start-accepted pulse
//   ap_done/ap_idle           completion pulse / idle status
//   dst_addr, size, times     job parameters, latched on start
//   err                       sticky error: any non-OKAY BRESP in the job
//   fifo_rd_en/fifo_rd_data   FIFO pop, data valid the cycle after the pop
//   fifo_empty                FIFO empty flag
//   m_axi_AW*/W*/B*           AXI4 write address, data and response channels
// -----------------------------------------------------------------------------
module aximm_burst_writer
    import aximm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [31:0]           size,
    input  logic [31:0]           times,
    output logic                  err,
    output logic                  fifo_rd_en,
    input  logic [WIDTH-1:0]      fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_axi_AWVALID,
    input  logic                  m_axi_AWREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_AWADDR,
    output logic [ID_WIDTH-1:0]   m_axi_AWID,
    output logic [7:0]            m_axi_AWLEN,
    output logic [2:0]            m_axi_AWSIZE,
    output logic [1:0]            m_axi_AWBURST,
    output logic                  m_axi_WVALID,
    input  logic                  m_axi_WREADY,
    output logic [WIDTH-1:0]      m_axi_WDATA,
    output logic [WIDTH/8-1:0]    m_axi_WSTRB,
    output logic                  m_axi_WLAST,
    input  logic                  m_axi_BVALID,
    output logic                  m_axi_BREADY,
    input  logic [1:0]            m_axi_BRESP,
    input  logic [ID_WIDTH-1:0]   m_axi_BID
);

    localparam int BYTES = WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, addr_q;
    logic [31:0]           times_q, pass_beats_q, rem_q;
    logic [8:0]            blen_q, popped_q, pushed_q;
    logic                  inflight_q;
    logic                  err_q;

    logic [31:0] beats;
    logic [12:0] bnd_bytes;
    logic [31:0] bnd_beats, cur_len, len_m1;
    logic        zero_job, pass_end, final_burst;
    logic        awvalid, rd_en, bready;
    logic        skid_in_ready, skid_valid, skid_last, skid_in_last;
    logic [1:0]  skid_cnt;
    logic        unused_ok;

    assign beats = size >> SZ;

    // Beats remaining before the next 4 KB boundary from the current address.
    assign bnd_bytes = 13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]};
    assign bnd_beats = 32'(bnd_bytes >> SZ);
    assign cur_len   = min3(rem_q, 32'(MAX_BURST), bnd_beats);
    assign len_m1    = cur_len - 32'd1;

    assign zero_job    = (pass_beats_q == 32'd0) || (times_q == 32'd0);
    assign pass_end    = (rem_q == {23'd0, blen_q});
    assign final_burst = pass_end && (times_q == 32'd1);

    assign unused_ok = ^{cur_len[31:9], len_m1[31:8], m_axi_BID};

    // FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // FSM next state and control outputs
    always_comb begin
        state_d  = state_q;
        ap_ready = 1'b0;
        awvalid  = 1'b0;
        rd_en    = 1'b0;
        bready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    ap_ready = 1'b1;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // An empty job is detected here, once the parameters are latched.
                if (zero_job) begin
                    state_d = ST_DONE;
                end else begin
                    awvalid = 1'b1;
                    if (m_axi_AWREADY) state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Never request more than the buffer can absorb, counting the
                // read whose data has not arrived yet.
                rd_en = !fifo_empty &&
                        (({1'b0, skid_cnt} + {2'b00, inflight_q}) < 3'd2) &&
                        (popped_q < blen_q);
                if (skid_valid && m_axi_WREADY && skid_last) state_d = ST_RESP;
            end
            ST_RESP: begin
                bready = 1'b1;
                if (m_axi_BVALID) state_d = final_burst ? ST_DONE : ST_ADDR;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Job/burst bookkeeping
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            base_q       <= '0;
            addr_q       <= '0;
            times_q      <= '0;
            pass_beats_q <= '0;
            rem_q        <= '0;
            blen_q       <= '0;
            popped_q     <= '0;
            pushed_q     <= '0;
            inflight_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (state_q == ST_IDLE && ap_start) begin
                base_q       <= dst_addr;
                addr_q       <= dst_addr;
                times_q      <= times;
                pass_beats_q <= beats;
                rem_q        <= beats;
                err_q        <= 1'b0;
            end
            if (awvalid && m_axi_AWREADY) begin
                blen_q   <= cur_len[8:0];
                popped_q <= '0;
                pushed_q <= '0;
            end else begin
                if (rd_en)      popped_q <= popped_q + 9'd1;
                if (inflight_q) pushed_q <= pushed_q + 9'd1;
            end
            if (state_q == ST_RESP && m_axi_BVALID) begin
                if (m_axi_BRESP != RESP_OKAY) err_q <= 1'b1;
                if (pass_end) begin
                    times_q <= times_q - 32'd1;
                    addr_q  <= base_q;
                    rem_q   <= pass_beats_q;
                end else begin
                    addr_q <= addr_q + (ADDR_WIDTH'(blen_q) << SZ);
                    rem_q  <= rem_q - {23'd0, blen_q};
                end
            end
        end
    end

    assign skid_in_last = (pushed_q == blen_q - 9'd1);

    wbeat_skid #(.WIDTH(WIDTH)) u_skid (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (inflight_q),
        .in_data   (fifo_rd_data),
        .in_last   (skid_in_last),
        .in_ready  (skid_in_ready),
        .out_valid (skid_valid),
        .out_data  (m_axi_WDATA),
        .out_last  (skid_last),
        .out_ready (m_axi_WREADY),
        .count     (skid_cnt)
    );

    logic unused_in_ready;
    assign unused_in_ready = skid_in_ready;

    assign ap_done       = (state_q == ST_DONE);
    assign ap_idle       = (state_q == ST_IDLE);
    assign err           = err_q;
    assign fifo_rd_en    = rd_en;
    assign m_axi_AWVALID = awvalid;
    assign m_axi_AWADDR  = addr_q;
    assign m_axi_AWLEN   = awvalid ? len_m1[7:0] : 8'd0;
    assign m_axi_AWID    = '0;
    assign m_axi_AWSIZE  = 3'(SZ);
    assign m_axi_AWBURST = BURST_INCR;
    assign m_axi_WVALID  = skid_valid;
    assign m_axi_WLAST   = skid_last;
    assign m_axi_WSTRB   = '1;
    assign m_axi_BREADY  = bready;

endmodule

// File: tb/tb_aximm_burst_writer.sv
module tb_aximm_burst_writer;

    logic        ap_clk, ap_rst_n, ap_start, ap_done, ap_idle, ap_ready;
    logic [63:0] dst_addr;
    logic [31:0] size, times;
    logic        err, fifo_rd_en, fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        m_axi_AWVALID, m_axi_AWREADY;
    logic [63:0] m_axi_AWADDR;
    logic [0:0]  m_axi_AWID, m_axi_BID;
    logic [7:0]  m_axi_AWLEN;
    logic [2:0]  m_axi_AWSIZE;
    logic [1:0]  m_axi_AWBURST, m_axi_BRESP;
    logic        m_axi_WVALID, m_axi_WREADY, m_axi_WLAST;
    logic [7:0]  m_axi_WDATA;
    logic [0:0]  m_axi_WSTRB;
    logic        m_axi_BVALID, m_axi_BREADY;

    aximm_burst_writer #(.WIDTH(8), .ADDR_WIDTH(64), .ID_WIDTH(1), .MAX_BURST(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .dst_addr(dst_addr), .size(size),
        .times(times), .err(err), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty),
        .m_axi_AWVALID(m_axi_AWVALID), .m_axi_AWREADY(m_axi_AWREADY),
        .m_axi_AWADDR(m_axi_AWADDR), .m_axi_AWID(m_axi_AWID), .m_axi_AWLEN(m_axi_AWLEN),
        .m_axi_AWSIZE(m_axi_AWSIZE), .m_axi_AWBURST(m_axi_AWBURST),
        .m_axi_WVALID(m_axi_WVALID), .m_axi_WREADY(m_axi_WREADY), .m_axi_WDATA(m_axi_WDATA),
        .m_axi_WSTRB(m_axi_WSTRB), .m_axi_WLAST(m_axi_WLAST),
        .m_axi_BVALID(m_axi_BVALID), .m_axi_BREADY(m_axi_BREADY),
        .m_axi_BRESP(m_axi_BRESP), .m_axi_BID(m_axi_BID)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int checks = 0;
    int errors = 0;

    // FIFO / slave model state
    logic [7:0]  mem [0:255];
    int          fifo_ptr = 0, fifo_avail = 0;
    bit          pop_pend = 0, b_pend = 0, b_drop = 0;
    bit          rand_stall = 0;
    int          bad_burst = -1;
    logic [63:0] aw_addr_log [0:15];
    logic [7:0]  aw_len_log  [0:15];
    logic [7:0]  w_log       [0:255];
    bit          wlast_log   [0:255];
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0, rd_cnt = 0;
    int          cyc = 0, done_cyc = 0, stab_err = 0;
    bit          held = 0, held_last = 0, err_chk_pend = 0;
    logic [7:0]  held_data;
    logic        err_after = 1'b0, err_at_b = 1'b1;

    // AXI slave + FIFO responder: inputs change at the falling edge, then the
    // settled handshake values (those the next rising edge will see) are logged.
    initial begin
        fifo_empty = 1'b1; fifo_rd_data = 8'h00;
        m_axi_AWREADY = 1'b0; m_axi_WREADY = 1'b0;
        m_axi_BVALID = 1'b0; m_axi_BRESP = 2'b00; m_axi_BID = 1'b0;
        forever begin
            @(negedge ap_clk);
            cyc++;
            if (!ap_rst_n) begin
                pop_pend = 0; b_pend = 0; b_drop = 0; held = 0;
                m_axi_BVALID = 1'b0;
                continue;
            end
            if (pop_pend) begin
                fifo_rd_data = mem[fifo_ptr[7:0]];
                fifo_ptr++;
                pop_pend = 0;
            end
            fifo_empty = (fifo_ptr >= fifo_avail) || (rand_stall && $urandom_range(0, 2) == 0);
            m_axi_AWREADY = rand_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            m_axi_WREADY  = rand_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (b_drop) begin m_axi_BVALID = 1'b0; b_drop = 0; end
            if (b_pend) begin
                m_axi_BVALID = 1'b1;
                m_axi_BRESP  = (b_cnt == bad_burst) ? 2'b10 : 2'b00;
                b_pend = 0;
            end
            #1;
            if (err_chk_pend) begin err_after = err; err_chk_pend = 0; end
            if (fifo_rd_en) begin pop_pend = 1; rd_cnt++; end
            if (m_axi_AWVALID && m_axi_AWREADY) begin
                aw_addr_log[aw_cnt[3:0]] = m_axi_AWADDR;
                aw_len_log[aw_cnt[3:0]]  = m_axi_AWLEN;
                aw_cnt++;
            end
            if (held) begin
                if (!m_axi_WVALID || m_axi_WDATA !== held_data || m_axi_WLAST !== held_last)
                    stab_err++;
                held = 0;
            end
            if (m_axi_WVALID && m_axi_WREADY) begin
                w_log[w_cnt[7:0]]     = m_axi_WDATA;
                wlast_log[w_cnt[7:0]] = m_axi_WLAST;
                w_cnt++;
                if (m_axi_WLAST) b_pend = 1;
            end else if (m_axi_WVALID) begin
                held = 1; held_data = m_axi_WDATA; held_last = m_axi_WLAST;
            end
            if (m_axi_BVALID && m_axi_BREADY) begin
                if (b_cnt == bad_burst) begin err_at_b = err; err_chk_pend = 1; end
                b_cnt++;
                b_drop = 1;
            end
            if (ap_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic load_fifo(input int n, input int seed);
        @(negedge ap_clk);
        #2;
        for (int i = 0; i < 256; i++) mem[i] = 8'((i * seed + 17) & 255);
        fifo_ptr = 0; fifo_avail = n;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0; rd_cnt = 0; stab_err = 0;
    endtask

    task automatic start_job(input logic [63:0] a, input int s, input int t,
                             output logic rdy, output int rcyc);
        @(negedge ap_clk);
        dst_addr = a; size = s; times = t; ap_start = 1'b1;
        #1;
        rdy  = ap_ready;
        rcyc = cyc;
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ap_clk);
            #2;
            if (done_cnt > 0) begin ok = 1; break; end
        end
        repeat (3) @(negedge ap_clk);
        #2;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; dst_addr = '0; size = '0; times = '0;
        repeat (3) @(negedge ap_clk);
        #1;
        checks++;
        if ({ap_idle, ap_done, ap_ready, m_axi_AWVALID, m_axi_WVALID, m_axi_BREADY, fifo_rd_en, err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 10000000",
                     {ap_idle, ap_done, ap_ready, m_axi_AWVALID, m_axi_WVALID, m_axi_BREADY, fifo_rd_en, err});
        end
        checks++;
        if (m_axi_AWADDR !== 64'h0 || m_axi_AWLEN !== 8'h0 || m_axi_WDATA !== 8'h0) begin
            errors++;
            $display("FAIL reset_data: AWADDR=%h AWLEN=%h WDATA=%h expected all zero", m_axi_AWADDR, m_axi_AWLEN, m_axi_WDATA);
        end
        checks++;
        if (m_axi_AWSIZE !== 3'd0 || m_axi_AWBURST !== 2'b01 || m_axi_WSTRB !== 1'b1 || m_axi_AWID !== 1'b0) begin
            errors++;
            $display("FAIL fixed_fields: AWSIZE=%0d AWBURST=%b WSTRB=%b AWID=%b expected 0 01 1 0",
                     m_axi_AWSIZE, m_axi_AWBURST, m_axi_WSTRB, m_axi_AWID);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] exp_addr [3];
        logic [7:0]  exp_len  [3];
        logic rdy; int rc; bit ok; bit exp_last;
        exp_addr = '{64'h1000, 64'h1010, 64'h1020};
        exp_len  = '{8'd15, 8'd15, 8'd7};
        load_fifo(40, 5);
        start_job(64'h1000, 40, 1, rdy, rc);
        wait_done(2000, ok);
        checks++;
        if (!ok || rdy !== 1'b1) begin errors++; $display("FAIL basic_done: done=%0d ready=%b expected 1 1", ok, rdy); end
        checks++;
        if (aw_cnt != 3) begin errors++; $display("FAIL basic_aw_cnt: got %0d expected 3", aw_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aw_addr_log[i] !== exp_addr[i] || aw_len_log[i] !== exp_len[i]) begin
                errors++;
                $display("FAIL basic_aw%0d: got %h/%0d expected %h/%0d", i, aw_addr_log[i], aw_len_log[i], exp_addr[i], exp_len[i]);
            end
        end
        checks++;
        if (w_cnt != 40) begin errors++; $display("FAIL basic_w_cnt: got %0d expected 40", w_cnt); end
        for (int i = 0; i < 40; i++) begin
            exp_last = (i == 15 || i == 31 || i == 39);
            checks++;
            if (w_log[i] !== mem[i] || wlast_log[i] !== exp_last) begin
                errors++;
                $display("FAIL basic_w%0d: got %h last %0d expected %h last %0d", i, w_log[i], wlast_log[i], mem[i], exp_last);
            end
        end
        checks++;
        if (done_cnt != 1 || ap_idle !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: done_cnt=%0d idle=%b err=%b expected 1 1 0", done_cnt, ap_idle, err);
        end
    endtask

    task automatic test_4k_boundary();
        logic rdy; int rc; bit ok;
        load_fifo(16, 3);
        start_job(64'h0FF8, 16, 1, rdy, rc);
        wait_done(1000, ok);
        checks++;
        if (!ok || aw_cnt != 2) begin errors++; $display("FAIL bnd_aw_cnt: done=%0d got %0d expected 2", ok, aw_cnt); end
        checks++;
        if (aw_addr_log[0] !== 64'h0FF8 || aw_len_log[0] !== 8'd7) begin
            errors++; $display("FAIL bnd_aw0: got %h/%0d expected 0ff8/7", aw_addr_log[0], aw_len_log[0]);
        end
        checks++;
        if (aw_addr_log[1] !== 64'h1000 || aw_len_log[1] !== 8'd7) begin
            errors++; $display("FAIL bnd_aw1: got %h/%0d expected 1000/7", aw_addr_log[1], aw_len_log[1]);
        end
        checks++;
        if (w_cnt != 16 || wlast_log[7] !== 1'b1 || wlast_log[15] !== 1'b1 || wlast_log[6] !== 1'b0) begin
            errors++; $display("FAIL bnd_w: count %0d last7 %0d last15 %0d last6 %0d expected 16 1 1 0",
                               w_cnt, wlast_log[7], wlast_log[15], wlast_log[6]);
        end
    endtask

    task automatic test_stall_repeat();
        logic rdy; int rc; bit ok;
        load_fifo(24, 11);
        rand_stall = 1;
        start_job(64'h2000, 8, 3, rdy, rc);
        wait_done(5000, ok);
        rand_stall = 0;
        checks++;
        if (!ok || aw_cnt != 3 || done_cnt != 1) begin
            errors++; $display("FAIL stall_cnt: done=%0d aw=%0d dones=%0d expected 1 3 1", ok, aw_cnt, done_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aw_addr_log[i] !== 64'h2000 || aw_len_log[i] !== 8'd7) begin
                errors++; $display("FAIL stall_aw%0d: got %h/%0d expected 2000/7", i, aw_addr_log[i], aw_len_log[i]);
            end
        end
        checks++;
        if (w_cnt != 24) begin errors++; $display("FAIL stall_w_cnt: got %0d expected 24", w_cnt); end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (w_log[i] !== mem[i] || wlast_log[i] !== ((i % 8) == 7)) begin
                errors++; $display("FAIL stall_w%0d: got %h last %0d expected %h last %0d", i, w_log[i], wlast_log[i], mem[i], (i % 8) == 7);
            end
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable beats expected 0", stab_err); end
    endtask

    task automatic test_zero_job();
        logic rdy; int rc; bit ok;
        load_fifo(16, 7);
        start_job(64'h5000, 16, 0, rdy, rc);
        wait_done(50, ok);
        checks++;
        if (!ok || rdy !== 1'b1 || done_cyc - rc != 2) begin
            errors++; $display("FAIL zero_times_timing: done=%0d ready=%b latency=%0d expected 1 1 2", ok, rdy, done_cyc - rc);
        end
        checks++;
        if (aw_cnt != 0 || rd_cnt != 0) begin
            errors++; $display("FAIL zero_times_quiet: aw=%0d rd=%0d expected 0 0", aw_cnt, rd_cnt);
        end
        load_fifo(16, 7);
        start_job(64'h5000, 0, 1, rdy, rc);
        wait_done(50, ok);
        checks++;
        if (!ok || done_cyc - rc != 2 || aw_cnt != 0 || rd_cnt != 0) begin
            errors++; $display("FAIL zero_size: done=%0d latency=%0d aw=%0d rd=%0d expected 1 2 0 0", ok, done_cyc - rc, aw_cnt, rd_cnt);
        end
    endtask

    task automatic test_bresp_err();
        logic rdy; int rc; bit ok;
        load_fifo(48, 9);
        bad_burst = 1;
        err_at_b = 1'b1; err_after = 1'b0;
        start_job(64'h3000, 48, 1, rdy, rc);
        wait_done(2000, ok);
        bad_burst = -1;
        checks++;
        if (!ok || aw_cnt != 3 || aw_addr_log[2] !== 64'h3020) begin
            errors++; $display("FAIL err_third_burst: done=%0d aw=%0d addr2=%h expected 1 3 3020", ok, aw_cnt, aw_addr_log[2]);
        end
        checks++;
        if (err_at_b !== 1'b0 || err_after !== 1'b1) begin
            errors++; $display("FAIL err_timing: before=%b after=%b expected 0 1", err_at_b, err_after);
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
        load_fifo(4, 2);
        start_job(64'h6000, 4, 1, rdy, rc);
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
        wait_done(500, ok);
        checks++;
        if (!ok || w_cnt != 4 || err !== 1'b0) begin
            errors++; $display("FAIL err_clean_run: done=%0d w=%0d err=%b expected 1 4 0", ok, w_cnt, err);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic rdy; int rc; bit ok; bit hit;
        load_fifo(40, 13);
        start_job(64'h7000, 40, 1, rdy, rc);
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge ap_clk);
            #2;
            if (w_cnt >= 5) begin hit = 1; break; end
        end
        checks++;
        if (!hit || m_axi_AWVALID !== 1'b0 || m_axi_BREADY !== 1'b0) begin
            errors++; $display("FAIL midrst_reach_data: reached=%0d awvalid=%b bready=%b expected 1 0 0", hit, m_axi_AWVALID, m_axi_BREADY);
        end
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({ap_idle, ap_done, ap_ready, m_axi_AWVALID, m_axi_WVALID, m_axi_BREADY, fifo_rd_en, err} !== 8'b1000_0000 ||
            m_axi_AWADDR !== 64'h0 || m_axi_AWLEN !== 8'h0 || m_axi_WDATA !== 8'h0) begin
            errors++;
            $display("FAIL midrst_outputs: ctrl=%b AWADDR=%h AWLEN=%h WDATA=%h expected 10000000 0 0 0",
                     {ap_idle, ap_done, ap_ready, m_axi_AWVALID, m_axi_WVALID, m_axi_BREADY, fifo_rd_en, err},
                     m_axi_AWADDR, m_axi_AWLEN, m_axi_WDATA);
        end
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        load_fifo(16, 21);
        start_job(64'h4000, 16, 1, rdy, rc);
        wait_done(1000, ok);
        checks++;
        if (!ok || aw_cnt != 1 || aw_addr_log[0] !== 64'h4000 || aw_len_log[0] !== 8'd15) begin
            errors++; $display("FAIL midrst_rerun_aw: done=%0d aw=%0d %h/%0d expected 1 1 4000/15",
                               ok, aw_cnt, aw_addr_log[0], aw_len_log[0]);
        end
        checks++;
        if (w_cnt != 16 || done_cnt != 1) begin
            errors++; $display("FAIL midrst_rerun_cnt: w=%0d dones=%0d expected 16 1", w_cnt, done_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (w_log[i] !== mem[i] || wlast_log[i] !== (i == 15)) begin
                errors++; $display("FAIL midrst_w%0d: got %h last %0d expected %h last %0d", i, w_log[i], wlast_log[i], mem[i], i == 15);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k_boundary();
        test_stall_repeat();
        test_zero_job();
        test_bresp_err();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aximm_burst_writer.md
AXIMM_BURST_WRITER -- requirements
Module: aximm_burst_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: AXI write data width in bits, power of two, at least 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: AXI address width.
REQ-003 SHALL have parameter ID_WIDTH, default 1: AXI ID width.
REQ-004 SHALL have parameter MAX_BURST, default 16: maximum beats per burst, power of two, 1 to 256.
REQ-005 SHALL have ports, in this order:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- ap_start  in  1  start request.
- ap_done  out  1  completion pulse.
- ap_idle  out  1  high while IDLE.
- ap_ready  out  1  start-accepted pulse.
- dst_addr  in  ADDR_WIDTH  destination byte address.
- size  in  32  bytes per pass.
- times  in  32  pass count.
- err  out  1  sticky BRESP error flag.
- fifo_rd_en  out  1  FIFO pop.
- fifo_rd_data  in  WIDTH  FIFO data, valid one cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty.
- m_axi_AWVALID/AWREADY/AWADDR/AWID/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]  AXI4 write address channel.
- m_axi_WVALID/WREADY/WDATA/WSTRB/WLAST  AXI4 write data channel.
- m_axi_BVALID/BREADY/BRESP[1:0]/BID  AXI4 write response channel.

Function
REQ-006 SHALL use states IDLE, ADDR, DATA, RESP, DONE.
REQ-007 IDLE with ap_start=1 SHALL:
- pulse ap_ready for one cycle;
- latch dst_addr, times, and beats = size >> log2(WIDTH/8);
- clear err;
- go to ADDR.
REQ-008 If latched beats==0 or times==0, the block SHALL go to DONE instead, with no AXI or FIFO activity.
REQ-009 Burst length SHALL be min(remaining beats in pass, MAX_BURST, beats left to next 4 KB boundary); AWLEN = length-1.
REQ-010 Burst fields SHALL be fixed: AWSIZE=log2(WIDTH/8), AWBURST=2'b01, AWID=0, WSTRB all ones.
REQ-011 ADDR SHALL assert AWVALID with stable AWADDR/AWLEN until AWREADY, then go to DATA.
REQ-012 DATA SHALL hold a 2-entry skid buffer.
REQ-013 DATA SHALL assert fifo_rd_en only when fifo_empty=0, buffer occupancy plus in-flight reads < 2, and popped beats < burst length.
REQ-014 WVALID SHALL equal buffer non-empty; WDATA/WLAST SHALL stay stable while WVALID=1 and WREADY=0.
REQ-015 WLAST SHALL be asserted on exactly the final beat of each burst; WREADY on that beat SHALL move to RESP.
REQ-016 RESP SHALL assert BREADY until BVALID.
REQ-017 In RESP, BRESP!=2'b00 SHALL set err; transfer SHALL continue regardless.
REQ-018 After each response the address SHALL advance by (AWLEN+1)*WIDTH/8.
REQ-019 At pass end, if passes remain, the address SHALL reload dst_addr and a new pass SHALL begin in ADDR.
REQ-020 After the final response the block SHALL enter DONE.
REQ-021 DONE SHALL pulse ap_done for one cycle and return to IDLE; ap_idle SHALL be 1 only in IDLE.
REQ-022 Only one burst SHALL be outstanding; AW of burst n+1 SHALL not issue before B of burst n.
REQ-023 ap_start outside IDLE SHALL be ignored.
REQ-024 Trailing size bytes below WIDTH/8 SHALL be dropped.

Reset
REQ-025 On ap_rst_n=0, immediately and asynchronously:
- state=IDLE;
- all VALID/READY/rd_en/ap_done/ap_ready/err = 0;
- ap_idle=1;
- skid buffer emptied;
- AWADDR/AWLEN/WDATA = 0.
REQ-026 Reset mid-burst SHALL abandon the transfer without completing it; the next ap_start SHALL start cleanly.

Structure
REQ-027 State encoding and AXI constants (BURST_INCR, RESP_OKAY, 4 KB boundary) SHALL live in shared package aximm_pkg.
REQ-028 The skid buffer SHALL be sub-module wbeat_skid (2 entries, valid/ready).

Verification
REQ-029 WIDTH=8, dst_addr=0x1000, size=40, times=1 -> AW 0x1000/15, 0x1010/15, 0x1020/7; 40 W beats in FIFO order; one ap_done.
REQ-030 dst_addr=0x0FF8, size=16 -> AW 0x0FF8/AWLEN 7, then 0x1000/AWLEN 7; no burst crosses 4 KB.
REQ-031 size=8, times=3, random WREADY/AWREADY and fifo_empty stalls -> three identical bursts at dst_addr; no lost or duplicated data; WDATA stable under stall.
REQ-032 times=0 -> ap_ready, then ap_done two cycles later; AWVALID and fifo_rd_en never asserted.
REQ-033 BRESP=2'b10 on the second of three bursts -> err=1 from that cycle; third burst still issued; err cleared at next ap_start.
REQ-034 ap_rst_n low during DATA beat 5 -> all outputs at reset values same cycle; subsequent size=16 run completes correctly.
